// File: rtl/ram_block_copier.sv
// ram_block_copier: single-port-pair copy engine for a true dual-port RAM.
// Port A is used read-only as the source, port B write-only as the
// destination. One word moves per clock; writes trail reads by one cycle
// to absorb the RAM's registered read. Overlapping ranges are handled by
// choosing the walk direction at start so no unread source word is
// overwritten.
module ram_block_copier #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_cnt;      // reads still to issue, including current
    logic              r_desc;
    logic [ADDR_W-1:0] r_rd_addr;  // source address of the current read step
    logic [ADDR_W-1:0] r_rd_dst;   // destination paired with the current read
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_we;

    logic [ADDR_W:0]   w_len_eff;
    logic [ADDR_W:0]   w_len_m1;
    logic [ADDR_W-1:0] w_last_off;
    logic [ADDR_W-1:0] w_dist;
    logic              w_desc;
    logic [ADDR_W-1:0] w_first_rd;
    logic [ADDR_W-1:0] w_first_dst;

    // Start-time decode: saturated length, direction and first step addresses.
    always_comb begin
        w_len_eff   = (len > DEPTH) ? DEPTH : len;
        w_len_m1    = w_len_eff - ONE;
        w_last_off  = w_len_m1[ADDR_W-1:0];
        w_dist      = dst_addr - src_addr;
        // Destination strictly inside the source range ahead of the read
        // pointer: walk from the top so every source word is read before
        // it can be overwritten. D = 0 is a harmless self-copy.
        w_desc      = (w_dist != '0) && ({1'b0, w_dist} < w_len_eff);
        w_first_rd  = w_desc ? (src_addr + w_last_off) : src_addr;
        w_first_dst = w_desc ? (dst_addr + w_last_off) : dst_addr;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = (w_len_eff == '0) ? S_DONE : S_RUN;
            S_RUN:   if (r_cnt == ONE) w_next = S_FLUSH;
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register, step pointers and the one-cycle-delayed write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_desc    <= 1'b0;
            r_rd_addr <= '0;
            r_rd_dst  <= '0;
            r_wr_addr <= '0;
            r_we      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next;
            r_we    <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_wr_addr <= r_rd_dst;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt     <= w_len_eff;
                        r_desc    <= w_desc;
                        r_rd_addr <= w_first_rd;
                        r_rd_dst  <= w_first_dst;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - ONE;
                    if (r_cnt != ONE) begin
                        if (r_desc) begin
                            r_rd_addr <= r_rd_addr - 1'b1;
                            r_rd_dst  <= r_rd_dst - 1'b1;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                            r_rd_dst  <= r_rd_dst + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign done        = (r_state == S_DONE);
    assign mem_rd_addr = r_rd_addr;
    assign mem_we      = r_we;
    assign mem_wr_addr = r_wr_addr;
    assign mem_wr_data = mem_rd_data;

endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier: a behavioural 64x8 dual-port RAM, a reference
// copy model that pushes expected writes to a scoreboard queue at start,
// and per-cycle checks of busy/done/mem_we/mem_rd_addr.
module tb_ram_block_copier;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_we;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;

    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int            rd_exp  [DEPTH];
    wr_t           exp_q   [$];

    int checks = 0;
    int errors = 0;

    ram_block_copier #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .mem_we      (mem_we),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    // True dual-port RAM: registered read on A (old data on collision), write on B.
    always @(posedge clk) begin
        mem_rd_data <= ram[mem_rd_addr];
        if (mem_we) ram[mem_wr_addr] <= mem_wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard: every write the DUT issues must match the next queued one.
    wr_t got;
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_wr_addr), 32'hFFFF_FFFF);
            end else begin
                got = exp_q.pop_front();
                check("wr_addr", 32'(mem_wr_addr), 32'(got.addr));
                check("wr_data", 32'(mem_wr_data), 32'(got.data));
            end
        end
    end

    task automatic preload(input int base);
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = 8'(i + base);
            ref_mem[i] = 8'(i + base);
        end
    endtask

    // Reference model. Read of step i sees writes of steps up to i-2 (the
    // write of step i-1 lands on the same edge and port A returns old data).
    // Only the first max_steps writes are queued/committed.
    task automatic plan_copy(input int s, input int d, input int l,
                             input int max_steps, output int n);
        int dd, off, ra, wa, pa;
        logic [DW-1:0] dat, pd;
        bit desc;
        n    = (l > DEPTH) ? DEPTH : l;
        dd   = (d - s) & (DEPTH - 1);
        desc = (dd >= 1) && (dd <= n - 1);
        pa   = 0;
        pd   = '0;
        for (int i = 0; i < n; i++) begin
            off       = desc ? (n - 1 - i) : i;
            ra        = (s + off) & (DEPTH - 1);
            wa        = (d + off) & (DEPTH - 1);
            rd_exp[i] = ra;
            dat       = ref_mem[ra];
            if (i >= 1 && (i - 1) < max_steps) ref_mem[pa] = pd;
            if (i < max_steps) exp_q.push_back('{addr: AW'(wa), data: dat});
            pa = wa;
            pd = dat;
        end
        if (n >= 1 && (n - 1) < max_steps) ref_mem[pa] = pd;
    endtask

    task automatic compare_ram(input string tag);
        for (int i = 0; i < DEPTH; i++) check(tag, 32'(ram[i]), 32'(ref_mem[i]));
    endtask

    // One copy with cycle-accurate checks; spam keeps start high (with
    // scrambled address/length inputs) through the copy until cycle n+2.
    task automatic run_copy(input int s, input int d, input int l, input bit spam);
        int n;
        plan_copy(s, d, l, DEPTH, n);
        @(negedge clk);
        start    = 1'b1;
        src_addr = AW'(s);
        dst_addr = AW'(d);
        len      = (AW + 1)'(l);
        @(posedge clk);
        for (int cyc = 1; cyc <= n + 3; cyc++) begin
            @(negedge clk);
            if (spam) begin
                start    = (cyc <= n + 1);
                src_addr = AW'($urandom);
                dst_addr = AW'($urandom);
                len      = (AW + 1)'($urandom);
            end else begin
                start = 1'b0;
            end
            if (n == 0) begin
                check("len0_done", 32'(done), 32'(cyc == 1));
                check("len0_busy", 32'(busy), 32'(0));
                check("len0_we", 32'(mem_we), 32'(0));
            end else begin
                if (cyc != n + 1) check("busy", 32'(busy), 32'(cyc <= n));
                check("we", 32'(mem_we), 32'(cyc >= 2 && cyc <= n + 1));
                check("done", 32'(done), 32'(cyc == n + 2));
                if (cyc <= n) check("rd_addr", 32'(mem_rd_addr), 32'(rd_exp[cyc-1]));
            end
        end
        start = 1'b0;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        compare_ram("ram_content");
    endtask

    initial begin
        int n;
        preload(8'h10);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_we", 32'(mem_we), 32'(0));
        check("rst_rd_addr", 32'(mem_rd_addr), 32'(0));
        check("rst_wr_addr", 32'(mem_wr_addr), 32'(0));
        rst_n = 1'b1;

        // Basic ascending copy.
        run_copy(0, 32, 8, 1'b0);
        for (int i = 0; i < 8; i++) check("basic_dst", 32'(ram[32+i]), 32'(8'h10 + i));
        for (int i = 0; i < 8; i++) check("basic_src", 32'(ram[i]), 32'(8'h10 + i));

        // Overlap, destination ahead of source: descending.
        preload(0);
        run_copy(4, 6, 5, 1'b0);
        for (int i = 0; i < 5; i++) check("fwd_overlap", 32'(ram[6+i]), 32'(4 + i));

        // Overlap, destination behind source: ascending.
        preload(0);
        run_copy(6, 4, 5, 1'b0);
        for (int i = 0; i < 5; i++) check("bwd_overlap", 32'(ram[4+i]), 32'(6 + i));

        // Wrap-around, then saturated length (64 words, done in cycle 66).
        preload(0);
        run_copy(62, 20, 4, 1'b0);
        check("wrap_20", 32'(ram[20]), 32'(62));
        check("wrap_21", 32'(ram[21]), 32'(63));
        check("wrap_22", 32'(ram[22]), 32'(0));
        check("wrap_23", 32'(ram[23]), 32'(1));
        run_copy(62, 20, 100, 1'b0);

        // Zero length, start held during a copy, self-copy.
        preload(8'h40);
        run_copy(10, 30, 0, 1'b0);
        run_copy(3, 40, 8, 1'b1);
        run_copy(5, 5, 10, 1'b0);

        // Reset right after the fifth edge of a 16-word copy: writes of
        // destination words 0..3 have landed, nothing after.
        preload(8'h20);
        plan_copy(0, 48, 16, 4, n);
        @(negedge clk);
        start    = 1'b1;
        src_addr = AW'(0);
        dst_addr = AW'(48);
        len      = (AW + 1)'(16);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_we", 32'(mem_we), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_writes", 32'(exp_q.size()), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_ram("after_reset");
        run_copy(50, 10, 6, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
